// File: rtl/lsu_stage.sv
// rtl/lsu_stage.sv - single-outstanding load/store unit between execute and data memory
module lsu_stage #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  alucode,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   input  logic [4:0]  rd_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        resp_valid,
   output logic        resp_err,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   localparam logic [5:0] ALU_LB  = 6'd18;
   localparam logic [5:0] ALU_LH  = 6'd19;
   localparam logic [5:0] ALU_LW  = 6'd20;
   localparam logic [5:0] ALU_LBU = 6'd21;
   localparam logic [5:0] ALU_LHU = 6'd22;
   localparam logic [5:0] ALU_SB  = 6'd23;
   localparam logic [5:0] ALU_SH  = 6'd24;
   localparam logic [5:0] ALU_SW  = 6'd25;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   function automatic logic is_load(input logic [5:0] op);
      return (op == ALU_LB) || (op == ALU_LH) || (op == ALU_LW) ||
             (op == ALU_LBU) || (op == ALU_LHU);
   endfunction

   function automatic logic is_store(input logic [5:0] op);
      return (op == ALU_SB) || (op == ALU_SH) || (op == ALU_SW);
   endfunction

   logic [1:0]  state;
   logic [5:0]  op_q;
   logic [31:0] addr_q;
   logic [31:0] sd_q;
   logic [4:0]  rd_q;
   logic [15:0] cnt;
   logic        err_q;
   logic [31:0] ld_q;

   logic        accept;
   logic        misaligned;
   logic [16:0] cnt_inc;
   logic [1:0]  off_q;
   logic        st_we;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_next;

   assign accept  = req_valid && (state == S_IDLE) && (is_load(alucode) || is_store(alucode));
   assign cnt_inc = {1'b0, cnt} + 17'd1;
   assign off_q   = addr_q[1:0];

   always_comb begin
      misaligned = 1'b0;
      case (alucode)
         ALU_LH, ALU_LHU, ALU_SH: misaligned = addr[0];
         ALU_LW, ALU_SW:          misaligned = (addr[1:0] != 2'b00);
         default:                 misaligned = 1'b0;
      endcase
   end

   always_comb begin
      st_we    = 1'b0;
      st_be    = 4'b1111;
      st_wdata = sd_q;
      case (op_q)
         ALU_SB: begin
            st_we    = 1'b1;
            st_be    = 4'b0001 << off_q;
            st_wdata = {4{sd_q[7:0]}};
         end
         ALU_SH: begin
            st_we    = 1'b1;
            st_be    = off_q[1] ? 4'b1100 : 4'b0011;
            st_wdata = {2{sd_q[15:0]}};
         end
         ALU_SW:  st_we = 1'b1;
         default: st_we = 1'b0;
      endcase
   end

   always_comb begin
      case (off_q)
         2'd0:    ld_byte = dmem_rdata[7:0];
         2'd1:    ld_byte = dmem_rdata[15:8];
         2'd2:    ld_byte = dmem_rdata[23:16];
         default: ld_byte = dmem_rdata[31:24];
      endcase
      ld_half = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
      case (op_q)
         ALU_LB:  ld_next = {{24{ld_byte[7]}}, ld_byte};
         ALU_LBU: ld_next = {24'd0, ld_byte};
         ALU_LH:  ld_next = {{16{ld_half[15]}}, ld_half};
         ALU_LHU: ld_next = {16'd0, ld_half};
         default: ld_next = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         op_q   <= 6'd0;
         addr_q <= 32'd0;
         sd_q   <= 32'd0;
         rd_q   <= 5'd0;
         cnt    <= 16'd0;
         err_q  <= 1'b0;
         ld_q   <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_q   <= alucode;
                  addr_q <= addr;
                  sd_q   <= store_data;
                  rd_q   <= rd_in;
                  cnt    <= 16'd0;
                  ld_q   <= 32'd0;
                  // misaligned ops never touch the memory port
                  if (misaligned) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     err_q <= 1'b0;
                     state <= S_ACCESS;
                  end
               end
            end
            S_ACCESS: begin
               cnt <= cnt_inc[15:0];
               if (dmem_ack) begin
                  ld_q  <= ld_next;
                  err_q <= 1'b0;
                  state <= S_DONE;
               end else if (cnt_inc == 17'(MAX_WAIT)) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_ready  = (state == S_IDLE);
   assign dmem_req   = (state == S_ACCESS);
   assign dmem_we    = dmem_req & st_we;
   assign dmem_be    = dmem_req ? st_be : 4'b0000;
   assign dmem_addr  = dmem_req ? {addr_q[31:2], 2'b00} : 32'd0;
   assign dmem_wdata = dmem_req ? st_wdata : 32'd0;

   assign resp_valid = (state == S_DONE);
   assign resp_err   = resp_valid & err_q;
   assign wb_valid   = resp_valid & ~err_q & is_load(op_q) & (rd_q != 5'd0);
   assign wb_rd      = rd_q;
   assign wb_data    = ld_q;

endmodule

// File: tb/tb_lsu_stage.sv
// tb/tb_lsu_stage.sv - directed and randomized checks of lsu_stage against a behavioural model
module tb_lsu_stage;

   localparam int unsigned MW = 4;

   localparam logic [5:0] ALU_ADD = 6'd1;
   localparam logic [5:0] ALU_LB  = 6'd18;
   localparam logic [5:0] ALU_LH  = 6'd19;
   localparam logic [5:0] ALU_LW  = 6'd20;
   localparam logic [5:0] ALU_LBU = 6'd21;
   localparam logic [5:0] ALU_LHU = 6'd22;
   localparam logic [5:0] ALU_SB  = 6'd23;
   localparam logic [5:0] ALU_SH  = 6'd24;
   localparam logic [5:0] ALU_SW  = 6'd25;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [5:0]  alucode = 6'd0;
   logic [31:0] addr = 32'd0;
   logic [31:0] store_data = 32'd0;
   logic [4:0]  rd_in = 5'd0;
   logic        dmem_req;
   logic        dmem_we;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = 32'd0;
   logic        resp_valid;
   logic        resp_err;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int failures = 0;

   lsu_stage #(.MAX_WAIT(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .alucode(alucode), .addr(addr), .store_data(store_data), .rd_in(rd_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .resp_valid(resp_valid), .resp_err(resp_err),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int op_size(input logic [5:0] op);
      if (op == ALU_LB || op == ALU_LBU || op == ALU_SB) return 1;
      if (op == ALU_LH || op == ALU_LHU || op == ALU_SH) return 2;
      return 4;
   endfunction

   function automatic bit op_store(input logic [5:0] op);
      return op == ALU_SB || op == ALU_SH || op == ALU_SW;
   endfunction

   function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] a,
                                              input logic [31:0] rdata);
      logic [31:0] sh;
      logic [31:0] v;
      sh = rdata >> (8 * a[1:0]);
      case (op)
         ALU_LB:  begin v = sh & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
         ALU_LBU:       v = sh & 32'hFF;
         ALU_LH:  begin v = sh & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
         ALU_LHU:       v = sh & 32'hFFFF;
         default:       v = rdata;
      endcase
      return v;
   endfunction

   // ack_delay counts request cycles before the acking one; >= MW means never ack
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [4:0] rd, input int ack_delay, input logic [31:0] rdata);
      int size;
      bit mis;
      bit got;
      int reqc;
      int lat;
      int exp_reqc;
      bit exp_err;
      logic [31:0] exp_be;
      logic [31:0] exp_wd;
      size = op_size(op);
      mis = (a % size) != 0;
      exp_be = op_store(op) ? (((32'd1 << size) - 1) << a[1:0]) : 32'hF;
      exp_wd = (size == 1) ? sd[7:0] * 32'h0101_0101 :
               (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
      if (mis) begin exp_reqc = 0; exp_err = 1; end
      else if (ack_delay < MW) begin exp_reqc = ack_delay + 1; exp_err = 0; end
      else begin exp_reqc = MW; exp_err = 1; end
      got = 0; reqc = 0; lat = -1;

      @(negedge clk);
      req_valid = 1; alucode = op; addr = a; store_data = sd; rd_in = rd;
      chk("ready_idle", req_ready, 1);
      @(negedge clk);
      req_valid = 0;
      for (int i = 0; i < 300 && !got; i++) begin
         chk("ready_busy", req_ready, 0);
         if (resp_valid) begin
            got = 1; lat = i; dmem_ack = 0;
            chk("resp_err", resp_err, exp_err);
            chk("wb_valid", wb_valid, !op_store(op) && !exp_err && rd != 0);
            if (!op_store(op) && !exp_err && rd != 0) begin
               chk("wb_rd", wb_rd, rd);
               chk("wb_data", wb_data, model_load(op, a, rdata));
            end
         end else begin
            if (dmem_req) begin
               chk("dmem_addr", dmem_addr, a & 32'hFFFF_FFFC);
               chk("dmem_we", dmem_we, op_store(op));
               chk("dmem_be", dmem_be, exp_be);
               if (op_store(op)) chk("dmem_wdata", dmem_wdata, exp_wd);
               dmem_ack = (reqc == ack_delay);
               dmem_rdata = dmem_ack ? rdata : $urandom;
               reqc++;
            end else begin
               dmem_ack = 0;
            end
            @(negedge clk);
         end
      end
      if (!got) chk("resp_timeout", 0, 1);
      chk("req_cycles", reqc, exp_reqc);
      chk("latency", lat, exp_reqc);
      @(negedge clk);
      chk("resp_pulse", resp_valid, 0);
      chk("wb_pulse", wb_valid, 0);
      chk("dmem_req_after", dmem_req, 0);
      chk("ready_after", req_ready, 1);
   endtask

   initial begin
      logic [5:0] ops[8];
      ops = '{ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU, ALU_SB, ALU_SH, ALU_SW};

      #1;
      chk("rst_ready", req_ready, 1);
      chk("rst_dmem_req", dmem_req, 0);
      chk("rst_dmem_be", dmem_be, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_wb_valid", wb_valid, 0);
      chk("rst_wb_data", wb_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;

      run_op(ALU_SW, 32'h100, 32'hDEAD_BEEF, 5'd9, 2, 32'h0);
      run_op(ALU_LB, 32'h203, 32'h0, 5'd5, 0, 32'h80FF_0000);
      run_op(ALU_LBU, 32'h203, 32'h0, 5'd5, 0, 32'h80FF_0000);
      run_op(ALU_SH, 32'h302, 32'h1234_ABCD, 5'd1, 0, 32'h0);
      run_op(ALU_SH, 32'h301, 32'h1234_ABCD, 5'd1, 0, 32'h0);
      run_op(ALU_LW, 32'h40, 32'h0, 5'd7, 99, 32'h1111_2222);
      run_op(ALU_LW, 32'h40, 32'h0, 5'd7, 3, 32'h1111_2222);
      run_op(ALU_LW, 32'h44, 32'h0, 5'd0, 1, 32'h3333_4444);

      @(negedge clk);
      req_valid = 1; alucode = ALU_ADD; addr = 32'h40;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("nonmem_ready", req_ready, 1);
         chk("nonmem_dmem_req", dmem_req, 0);
         chk("nonmem_resp", resp_valid, 0);
      end
      req_valid = 0;

      @(negedge clk);
      req_valid = 1; alucode = ALU_LW; addr = 32'h80; rd_in = 5'd3;
      @(negedge clk);
      req_valid = 0;
      chk("mid_dmem_req", dmem_req, 1);
      #2 rst_n = 0;
      #1;
      chk("async_dmem_req", dmem_req, 0);
      chk("async_ready", req_ready, 1);
      @(negedge clk);
      chk("abort_resp_rst", resp_valid, 0);
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_resp", resp_valid, 0);
         chk("abort_dmem_req", dmem_req, 0);
      end
      run_op(ALU_LHU, 32'h12, 32'h0, 5'd4, 0, 32'hF00D_0000);

      for (int n = 0; n < 40; n++) begin
         run_op(ops[$urandom_range(0, 7)], $urandom, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 5), $urandom);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
